mmio_bus_ctrl: RTL
==================

Name: mmio_bus_ctrl

Overview:
Parametrised memory-mapped bus controller between the CPU (mem_cmd/mem_addr/write_data/read_data) and a synchronous on-chip RAM plus N_IN input ports and N_OUT output ports.
- Replaces ad-hoc equality decode and tristate muxing with a registered read-data mux, a ready handshake and register-backed output ports.
- Adds input synchronisers and unmapped-access error reporting.
- Sits at top level between cpu and RAM/switch/LED/HEX wiring.

Parameters:
ADDR_W, 9, CPU address width
DATA_W, 16, bus data width
RAM_AW, 8, RAM address width; RAM region is mem_addr[ADDR_W-1]==0
PORT_W, 8, width of each I/O port (<= DATA_W)
N_OUT, 2, number of output port registers
N_IN, 2, number of input ports
OUT_BASE, 9'h100, address of output port 0; port i at OUT_BASE+i
IN_BASE, 9'h140, address of input port 0; port i at IN_BASE+i

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_cmd  in  2  00 NONE, 01 MREAD, 10 MWRITE, 11 treated as NONE
mem_addr  in  ADDR_W  transaction address
write_data  in  DATA_W  write data
read_data  out  DATA_W  registered read data
mem_ready  out  1  one-cycle completion pulse
bus_err  out  1  high with mem_ready when the access was unmapped
ram_addr  out  RAM_AW  = mem_addr[RAM_AW-1:0]
ram_write  out  1  RAM write strobe
ram_din  out  DATA_W  = write_data
ram_dout  in  DATA_W  RAM registered output (valid 1 cycle after address)
in_ports  in  N_IN*PORT_W  asynchronous inputs, port i at [i*PORT_W +: PORT_W]
out_ports  out  N_OUT*PORT_W  output port registers

Behaviour:
- FSM states: IDLE, RAM_WAIT, RESP. Reset (reset==0, async): state IDLE; read_data, out_ports, sync flops = 0; mem_ready = 0; bus_err = 0.
- IDLE: MREAD/MWRITE accepted at the clock edge.
  - RAM read -> RAM_WAIT.
  - All other accepts -> RESP.
  - NONE/11 -> stay IDLE.
- RAM_WAIT: read_data <= ram_dout; -> RESP.
- RESP: mem_ready=1 for exactly this cycle; mem_cmd ignored; -> IDLE. Requester holds cmd/addr/data stable from issue until mem_ready. Minimum spacing between accepts is 2 cycles for I/O and 3 for RAM reads.
- Decode priority (exclusive):
  - RAM when addr MSB=0.
  - OUT i when addr==OUT_BASE+i, i<N_OUT.
  - IN i when addr==IN_BASE+i, i<N_IN.
  - Otherwise unmapped.
- ram_write = (state==IDLE) & MWRITE & RAM hit, combinational, single cycle.
- Output write: out_ports[i] <= write_data[PORT_W-1:0] at the accept edge.
- Reads:
  - Input read: read_data <= {zero-extend, in_sync[i]} at the accept edge.
  - Output-port read: returns current register value zero-extended.
- Unmapped:
  - Read sets read_data <= 0; write has no effect.
  - bus_err=1 during the RESP cycle, otherwise 0.
- Input sync: two flops per bit; in_sync lags in_ports by 2 edges.
- read_data holds its value between reads; writes do not change it.
- Reset asserted mid-transaction aborts it: no mem_ready, no pending write completes, and RAM write is not asserted after reset.

Optional Feature:
MMIO_IRQ_EN.
- Defined: adds output port irq (1 bit) and a status register at IN_BASE+8'h10.
  - Per-bit rising-edge detect on port 0's in_sync sets sticky pending[PORT_W-1:0].
  - irq = |pending.
  - Reading status returns pending and clears it at the accept edge.
  - A new edge on the same cycle as the clear leaves that bit set.
  - Reset clears pending.
- Undefined: no irq port, no pending logic, and IN_BASE+8'h10 is unmapped (bus_err).

Test Plan:
- Reset low mid RAM_WAIT -> state IDLE, mem_ready=0, out_ports=0, read_data=0; after release, MREAD 9'h140 with in_ports[7:0]=8'h5A held >=2 cycles -> read_data=16'h005A, mem_ready pulse 1 cycle after accept.
- MWRITE 9'h100 data 16'hABCD -> out_ports[7:0]=8'hCD at accept edge, mem_ready next cycle, bus_err=0; MREAD 9'h100 -> read_data=16'h00CD.
- MWRITE 9'h005 data 16'h1234 -> ram_write=1 for exactly one cycle with ram_addr=8'h05; MREAD 9'h005 with ram_dout=16'h1234 -> read_data=16'h1234, mem_ready 2 cycles after accept.
- MREAD 9'h1FF -> read_data=0, bus_err=1 with mem_ready; MWRITE 9'h1FF -> out_ports unchanged, bus_err=1.
- mem_cmd=MREAD held continuously on 9'h141 -> mem_ready pulses every 2nd cycle, never two consecutive cycles; mem_cmd=11 -> no ready, state stays IDLE.
- (MMIO_IRQ_EN) in_ports[0] 0->1 -> irq=1 three edges later; read IN_BASE+8'h10 -> read_data=16'h0001, irq=0 next cycle; edge on bit 3 coincident with the clear -> pending=8'h08.

Source files
------------

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: CPU <-> synchronous RAM, output port registers, synchronised input ports.
// Optional `define MMIO_IRQ_EN adds an irq output and a read-to-clear edge status register at IN_BASE+8'h10.
module mmio_bus_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RAM_AW = 8,
  parameter int PORT_W = 8,
  parameter int N_OUT  = 2,
  parameter int N_IN   = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
  parameter logic [ADDR_W-1:0] IN_BASE  = 9'h140
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mem_cmd,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic                     mem_ready,
  output logic                     bus_err,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic                     ram_write,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout,
  input  logic [N_IN*PORT_W-1:0]   in_ports,
`ifdef MMIO_IRQ_EN
  output logic                     irq,
`endif
  output logic [N_OUT*PORT_W-1:0]  out_ports
);

  // state    | meaning
  // IDLE     | waiting for MREAD/MWRITE; accepts on the clock edge
  // RAM_WAIT | RAM read in flight, ram_dout captured on exit
  // RESP     | mem_ready (and bus_err if unmapped) for this one cycle
  typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t state, state_nxt;

  logic                    is_read, is_write, accept;
  logic                    ram_hit, status_hit, unmapped;
  logic [N_OUT-1:0]        out_sel;
  logic [N_IN-1:0]         in_sel;
  logic [DATA_W-1:0]       io_rdata;
  logic                    err_q;
  logic [N_OUT*PORT_W-1:0] out_q;
  logic [N_IN*PORT_W-1:0]  sync1, in_sync;
  logic [PORT_W-1:0]       status_val;

  assign is_read  = (mem_cmd == CMD_READ);
  assign is_write = (mem_cmd == CMD_WRITE);
  assign accept   = (state == IDLE) && (is_read || is_write);

  assign ram_addr  = mem_addr[RAM_AW-1:0];
  assign ram_din   = write_data;
  // Gated by reset so an aborted write never strobes the RAM while reset is held.
  assign ram_write = reset && (state == IDLE) && is_write && ram_hit;
  assign out_ports = out_q;

  // Exclusive decode: RAM, then output ports, then input ports, then status.
  always_comb begin
    ram_hit    = ~mem_addr[ADDR_W-1];
    out_sel    = '0;
    in_sel     = '0;
    status_hit = 1'b0;
    if (!ram_hit) begin
      for (int i = 0; i < N_OUT; i++) begin
        if (mem_addr == OUT_BASE + ADDR_W'(i)) out_sel[i] = 1'b1;
      end
      if (out_sel == '0) begin
        for (int i = 0; i < N_IN; i++) begin
          if (mem_addr == IN_BASE + ADDR_W'(i)) in_sel[i] = 1'b1;
        end
      end
`ifdef MMIO_IRQ_EN
      if (out_sel == '0 && in_sel == '0 && mem_addr == IN_BASE + ADDR_W'(8'h10))
        status_hit = 1'b1;
`endif
    end
    unmapped = !ram_hit && (out_sel == '0) && (in_sel == '0) && !status_hit;
  end

  // Selects are one-hot, so the read mux is an OR of gated sources; unmapped reads give zero.
  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (out_sel[i]) io_rdata = io_rdata | DATA_W'(out_q[i*PORT_W +: PORT_W]);
    end
    for (int i = 0; i < N_IN; i++) begin
      if (in_sel[i]) io_rdata = io_rdata | DATA_W'(in_sync[i*PORT_W +: PORT_W]);
    end
    if (status_hit) io_rdata = io_rdata | DATA_W'(status_val);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_ready = 1'b0;
    bus_err   = 1'b0;
    unique case (state)
      IDLE:     if (accept) state_nxt = (is_read && ram_hit) ? RAM_WAIT : RESP;
      RAM_WAIT: state_nxt = RESP;
      RESP: begin
        mem_ready = 1'b1;
        bus_err   = err_q;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= unmapped;
        if (is_write) begin
          for (int i = 0; i < N_OUT; i++) begin
            if (out_sel[i]) out_q[i*PORT_W +: PORT_W] <= write_data[PORT_W-1:0];
          end
        end
        if (is_read && !ram_hit) read_data <= io_rdata;
      end
      if (state == RAM_WAIT) read_data <= ram_dout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      in_sync <= '0;
    end else begin
      sync1   <= in_ports;
      in_sync <= sync1;
    end
  end

`ifdef MMIO_IRQ_EN
  logic [PORT_W-1:0] prev0, pending, rise;
  logic              status_clr;

  assign rise       = in_sync[PORT_W-1:0] & ~prev0;
  assign status_clr = accept && is_read && status_hit;
  assign status_val = pending;
  assign irq        = |pending;

  // A rise in the clearing cycle is ORed in after the clear so it is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev0   <= '0;
      pending <= '0;
    end else begin
      prev0   <= in_sync[PORT_W-1:0];
      pending <= (status_clr ? '0 : pending) | rise;
    end
  end
`else
  assign status_val = '0;
`endif

endmodule
